// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_reg command sequencer.
package shift_pkg;

    localparam int SR_W = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        RESULT
    } seq_state_t;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter holding the remaining shift count of the sequencer.
module seq_down_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    // Saturates at zero so a stray decrement cannot wrap to the maximum count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/shift_seq.sv
// Command sequencer driving a 4-bit load/shift register: load, N shifts, return result.
// Optional feature: SHIFT_SEQ_EARLY_STOP_EN stops shifting once the register reads zero.
module shift_seq
    import shift_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SR_W-1:0]  cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [SR_W-1:0]  d_out,
    output logic             ld,
    output logic             s_cnt,
    output logic             sr,
    output logic             sl,
    input  logic [SR_W-1:0]  q_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SR_W-1:0]  res_data,
    output logic [CNT_W-1:0] res_shifts
);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [SR_W-1:0]  data_q;
    logic             dir_q;
    logic [CNT_W-1:0] shifts_q;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_is_one;
    logic             cnt_is_zero;
    logic             cnt_dec;
    logic             shift_go;
    logic             accept;
    logic             load_skip;
    logic             stop_early;

    assign cmd_ready   = (state == IDLE) && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign cnt_is_zero = (cnt_val == '0);
    assign res_shifts  = shifts_q;

`ifdef SHIFT_SEQ_EARLY_STOP_EN
    // A zero register cannot change by shifting; skip straight to the result.
    assign load_skip  = (data_q == '0);
    assign stop_early = (q_in == '0);
`else
    assign load_skip  = 1'b0;
    assign stop_early = 1'b0;
`endif

    seq_down_cnt #(
        .CNT_W(CNT_W)
    ) u_remaining (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cmd_cnt),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            dir_q    <= DIR_RIGHT;
            shifts_q <= '0;
        end else if (accept) begin
            data_q   <= cmd_data;
            dir_q    <= cmd_dir;
            shifts_q <= '0;
        end else if (shift_go) begin
            shifts_q <= shifts_q + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        d_out     = '0;
        ld        = 1'b0;
        s_cnt     = 1'b0;
        sr        = 1'b0;
        sl        = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        cnt_dec   = 1'b0;
        shift_go  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                ld    = 1'b1;
                d_out = data_q;
                if (cnt_is_zero || load_skip) begin
                    state_nx = RESULT;
                end else begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (stop_early) begin
                    state_nx = RESULT;
                end else begin
                    s_cnt    = 1'b1;
                    sr       = (dir_q == DIR_RIGHT);
                    sl       = (dir_q == DIR_LEFT);
                    cnt_dec  = 1'b1;
                    shift_go = 1'b1;
                    if (cnt_is_one) begin
                        state_nx = RESULT;
                    end
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                res_data  = q_in;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_seq.sv
// Randomized self-checking bench for shift_seq with a behavioural shift_reg and result model.
module tb_shift_seq;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_data = '0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [3:0]       d_out;
    logic             ld, s_cnt, sr, sl;
    logic [3:0]       q;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [3:0]       res_data;
    logic [CNT_W-1:0] res_shifts;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          rr_mode = 0;

    always #5 clk = ~clk;

    shift_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_dir    (cmd_dir),
        .cmd_cnt    (cmd_cnt),
        .d_out      (d_out),
        .ld         (ld),
        .s_cnt      (s_cnt),
        .sr         (sr),
        .sl         (sl),
        .q_in       (q),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_shifts (res_shifts)
    );

    // Downstream shift_reg stand-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= '0;
        else if (ld)    q <= d_out;
        else if (s_cnt) q <= sr ? {1'b0, q[3:1]} : (sl ? {q[2:0], 1'b0} : q);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected result, shifts performed and command-to-result latency.
    task automatic model(input logic [3:0] d, input logic dir, input int n,
                         output logic [3:0] rd, output int sh, output int lat);
        logic [7:0] wide;
        wide = {4'b0000, d};
        rd   = dir ? 4'((wide << n) & 8'h0f) : 4'(wide >> n);
        sh   = n;
        lat  = n + 2;
`ifdef SHIFT_SEQ_EARLY_STOP_EN
        if (d == 4'd0) begin
            sh  = 0;
            lat = 2;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                if (4'(dir ? ((wide << k) & 8'h0f) : (wide >> k)) == 4'd0) begin
                    if (n > k) begin
                        sh  = k;
                        lat = k + 3;
                    end
                    break;
                end
            end
        end
`endif
    endtask

    // Transaction monitor and scoreboard.
    bit          pend = 0;
    bit          seen = 0;
    int          cyc = 0, acc_cyc = 0, ld_n = 0, sc_n = 0;
    logic [3:0]  exp_data;
    int          exp_sh, exp_lat;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 0;
            end else begin
                cyc++;
                if (sr && sl) check("sr_sl_both", 32'(1), 32'(0));
                if (pend) begin
                    if (ld)    ld_n++;
                    if (s_cnt) sc_n++;
                    if (res_valid) begin
                        if (!seen) begin
                            seen = 1;
                            check("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
                        end
                        check("res_data", 32'(res_data), 32'(exp_data));
                        check("res_shifts", 32'(res_shifts), 32'(exp_sh));
                        if (res_ready) begin
                            check("ld_pulses", 32'(ld_n), 32'(1));
                            check("shift_pulses", 32'(sc_n), 32'(exp_sh));
                            pend = 0;
                        end
                    end
                end else if (res_valid) begin
                    check("spurious_valid", 32'(1), 32'(0));
                end
                if (cmd_valid && cmd_ready) begin
                    if (pend) check("accept_busy", 32'(1), 32'(0));
                    model(cmd_data, cmd_dir, int'(cmd_cnt), exp_data, exp_sh, exp_lat);
                    pend = 1; seen = 0; acc_cyc = cyc; ld_n = 0; sc_n = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom % 2);
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [3:0] d, input logic dir, input int n, input bit hold);
        int budget = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_cnt = CNT_W'(n);
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) check("accept_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 0;
        while (pend && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("done_timeout", 32'(pend), 32'(0));
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cmd_ready, ld, s_cnt, sr, sl, res_valid, d_out, res_data, res_shifts});
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'(1));

        rr_mode = 0;
        send(4'b1011, 1'b0, 1, 0); wait_done();
        send(4'b1001, 1'b1, 0, 0); wait_done();
        send(4'b1000, 1'b0, 7, 0); wait_done();
        send(4'b0000, 1'b1, 3, 0); wait_done();

        rr_mode = 2;
        send(4'b0011, 1'b1, 2, 0);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'(1));
            check("hold_data", 32'(res_data), 32'(4'b1100));
        end
        rr_mode = 0;
        wait_done();

        // Reset while shifting.
        send(4'b1111, 1'b1, 7, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_shift_reset_outs", all_outs(), 32'(0));
        @(negedge clk);
        check("reset_hold_outs", all_outs(), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_mid_reset", 32'(cmd_ready), 32'(1));

        // Back-to-back commands with cmd_valid held through busy periods.
        rr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send(4'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1);
        end
        cmd_valid = 1'b0;
        wait_done();
        rr_mode = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Command sequencer that drives the 4-bit load/shift register (`shift_reg`) directly upstream of it. Accepts one command per handshake: a 4-bit load value, a shift direction and a shift count. It loads the register, issues the requested number of single-bit shifts, then returns the register contents read back on `q_in`. It is the only agent driving `ld`/`s_cnt`/`sr`/`sl`; `shift_reg` sits on the same `clk`/`rst`.

## Interface
- `CNT_W`, default 3: width of shift-count field; max count 2^CNT_W−1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: sequencer idle, command accepted on `cmd_valid & cmd_ready`.
- `cmd_data` in 4: value to load.
- `cmd_dir` in 1: 0 = shift right (zero into bit 3), 1 = shift left (zero into bit 0).
- `cmd_cnt` in CNT_W: number of shifts.
- `d_out` out 4: to `shift_reg.d_in`.
- `ld` out 1: to `shift_reg.ld`.
- `s_cnt` out 1: to `shift_reg.s_cnt`.
- `sr` out 1: to `shift_reg.sr`.
- `sl` out 1: to `shift_reg.sl`.
- `q_in` in 4: from `shift_reg.q`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed on `res_valid & res_ready`.
- `res_data` out 4: final register value (= `q_in` while in RESULT).
- `res_shifts` out CNT_W: shifts actually performed.

## Operation
- FSM states: IDLE, LOAD, SHIFT, RESULT. Command fields, direction and remaining count are registered at acceptance.
- IDLE: `cmd_ready`=1. On accept → LOAD.
- LOAD: `ld`=1, `d_out`=latched data. Next state: SHIFT if count≠0, else RESULT.
- SHIFT: `s_cnt`=1; `sr`=~dir, `sl`=dir (never both high). Remaining count decrements and `res_shifts` increments each cycle. Leave for RESULT in the cycle the remaining count reaches 1.
- RESULT: `res_valid`=1, `res_data`=`q_in`. `shift_reg` holds because `ld`=`s_cnt`=0. On `res_ready` → IDLE.
- Outside LOAD, `ld`=0 and `d_out`=0. Outside SHIFT, `s_cnt`=`sr`=`sl`=0.
- All control outputs are Moore-decoded from registered state. No combinational path from `cmd_*`/`res_ready` to any output.
- `res_shifts` is cleared on accept and holds its value through RESULT.
- Reset (any state, including mid-SHIFT) → IDLE. All outputs 0, `cmd_ready` forced 0 while `rst`=1. `shift_reg` clears simultaneously on the shared `rst`.

## Timing
- Accept at edge k. LOAD during cycle k..k+1. `q_in`=data after edge k+1.
- N shift cycles follow LOAD. `res_valid` rises after edge k+1+N (N=0: after edge k+1).
- Command-to-result latency N+2 cycles. Minimum command spacing N+3 cycles with `res_ready` held high.
- `cmd_valid` while busy: ignored, `cmd_ready`=0. The command must be held by the source.
- `res_valid` held until `res_ready`. `res_data` is stable because the register is frozen.
- The first edge after `rst` deassertion can accept a command.

## Configuration
- `SHIFT_SEQ_EARLY_STOP_EN` defined: in SHIFT, if `q_in`==0 at the start of a cycle, no shift is issued that cycle (`s_cnt`=0) and the FSM goes to RESULT. `res_shifts` reports shifts actually done.
  - Also applies to the first SHIFT cycle when `cmd_data`=0: `res_shifts`=0, latency 2.
- Undefined: all N shifts are always issued and `res_shifts`=`cmd_cnt`.

## Structure
- Package `shift_pkg`: state enum `seq_state_t`, constants `DIR_RIGHT`=0, `DIR_LEFT`=1, reg width `SR_W`=4.
- One sub-module `seq_down_cnt`: loadable down-counter, CNT_W wide, with load/decrement/`is_one` outputs. Instantiated for the remaining count.

## Test plan
- Reset: `rst` high mid-SHIFT → all outputs 0 and `cmd_ready`=0 during reset. After release, IDLE with `cmd_ready`=1.
- data=4'b1011, dir=0, cnt=1 → LOAD 1 cycle, 1 `sr` cycle. `res_data`=4'b0101, `res_shifts`=1, latency 3.
- data=4'b0011, dir=1, cnt=2 → `res_data`=4'b1100, `res_shifts`=2. `res_ready` held low 5 cycles: `res_valid` and data stable.
- data=4'b1001, cnt=0 → no `s_cnt` pulse. `res_data`=4'b1001, latency 2.
- data=4'b1000, dir=0, cnt=7 → with macro: 4 shifts, `res_data`=0, `res_shifts`=4. Without: 7 shifts, `res_shifts`=7.
- `cmd_valid` held through a busy command → second command accepted only in IDLE. `ld` pulses exactly once per accept. Back-to-back results correct.
